// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional bne support is enabled by defining MC_BNE_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       Jr,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic       BranchNE,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        IMM_EXEC  = 4'd10,
        IMM_WB    = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    // Immediate-op ALU function is shared by IMM_EXEC and IMM_WB.
    logic [2:0] imm_aluop;
    logic       imm_extop;
    always_comb begin
        imm_aluop = 3'b000;
        imm_extop = 1'b0;
        case (op)
            OP_ANDI: begin imm_aluop = 3'b100; imm_extop = 1'b1; end
            OP_ORI:  begin imm_aluop = 3'b101; imm_extop = 1'b1; end
            default: begin imm_aluop = 3'b000; imm_extop = 1'b0; end
        endcase
    end

    always_comb begin
        state_next  = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ExtOp       = 1'b0;
        BranchNE    = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        illegal_op  = 1'b0;

        case (state_reg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end else begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW:             state_next = MEM_ADDR;
                    OP_RTYPE:                 state_next = EXECUTE;
                    OP_BEQ:                   state_next = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:                   state_next = BRANCH;
`endif
                    OP_J:                     state_next = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = IMM_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (op == OP_SW) begin
                    state_next = MEM_WRITE;
                end else begin
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                state_next = mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                if (Jr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end else begin
                    state_next = ALU_WB;
                end
            end
            ALU_WB: begin
                ALUOp    = 3'b010;
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
`ifdef MC_BNE_EN
                BranchNE    = (op == OP_BNE);
`endif
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            IMM_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = imm_aluop;
                ExtOp      = imm_extop;
                state_next = IMM_WB;
            end
            IMM_WB: begin
                ALUOp    = imm_aluop;
                ExtOp    = imm_extop;
                RegWrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Reset is asynchronous, so outputs must drop with it rather than wait for the clock.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcA     = 1'b0;
            ExtOp       = 1'b0;
            BranchNE    = 1'b0;
            PCSource    = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 3'b000;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class through the FSM.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       Jr;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA, ExtOp, BranchNE;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .Jr(Jr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ExtOp(ExtOp), .BranchNE(BranchNE),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    logic [23:0] all_outs;
    assign all_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, RegWrite, RegDst, ALUSrcA, ExtOp, BranchNE,
                       PCSource, ALUSrcB, ALUOp, illegal_op, state};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'h23; Jr = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_all_zero", 32'(all_outs), 32'h0);
        step();
        chk("reset_hold_zero", 32'(all_outs), 32'h0);
        reset = 1'b0;
        #1;
        // 1: lw
        chk("lw_fetch_state", 32'(state), 32'd0);
        chk("lw_fetch_memread", 32'(MemRead), 32'd1);
        chk("lw_fetch_alusrcb", 32'(ALUSrcB), 32'd1);
        chk("lw_fetch_irwrite", 32'(IRWrite), 32'd1);
        step();
        chk("lw_decode_state", 32'(state), 32'd1);
        chk("lw_decode_alusrcb", 32'(ALUSrcB), 32'd3);
        step();
        chk("lw_memaddr_state", 32'(state), 32'd2);
        chk("lw_memaddr_srcs", 32'({ALUSrcA, ALUSrcB}), 32'b110);
        step();
        chk("lw_memread_state", 32'(state), 32'd3);
        chk("lw_memread_ctl", 32'({MemRead, IorD}), 32'b11);
        step();
        chk("lw_memwb_state", 32'(state), 32'd4);
        chk("lw_memwb_ctl", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);
        step();
        chk("lw_back_fetch", 32'(state), 32'd0);

        // 2: fetch stall
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_ir_pc", 32'({IRWrite, PCWrite}), 32'b00);
            step();
        end
        mem_ready = 1'b1; op = 6'h00; Jr = 1'b0;
        #1;
        chk("stall_release_ir_pc", 32'({IRWrite, PCWrite}), 32'b11);
        step();
        chk("stall_once_ir_pc", 32'({IRWrite, PCWrite}), 32'b00);

        // 3: R-type, then jr
        step();
        chk("r_exec_state", 32'(state), 32'd6);
        chk("r_exec_aluop", 32'(ALUOp), 32'b010);
        chk("r_exec_pcwrite", 32'(PCWrite), 32'd0);
        step();
        chk("r_aluwb_state", 32'(state), 32'd7);
        chk("r_aluwb_ctl", 32'({RegDst, RegWrite, MemtoReg}), 32'b110);
        step();
        chk("r_back_fetch", 32'(state), 32'd0);
        Jr = 1'b1;
        step();
        step();
        chk("jr_exec_state", 32'(state), 32'd6);
        chk("jr_exec_pc", 32'({PCWrite, PCSource, RegWrite}), 32'b1110);
        step();
        chk("jr_back_fetch", 32'(state), 32'd0);
        chk("jr_no_regwrite", 32'(RegWrite), 32'd0);
        Jr = 1'b0;

        // 4: beq, ori, addi, sw, j
        op = 6'h04;
        step();
        step();
        chk("beq_state", 32'(state), 32'd8);
        chk("beq_ctl", 32'({ALUOp, PCWriteCond, PCSource, BranchNE}), 32'b001_1_01_0);
        step();
        chk("beq_back_fetch", 32'(state), 32'd0);
        op = 6'h0D;
        step();
        step();
        chk("ori_exec_state", 32'(state), 32'd10);
        chk("ori_exec_ctl", 32'({ALUOp, ExtOp, ALUSrcA, ALUSrcB}), 32'b101_1_1_10);
        step();
        chk("ori_wb_state", 32'(state), 32'd11);
        chk("ori_wb_ctl", 32'({ALUOp, ExtOp, RegWrite, RegDst}), 32'b101_1_1_0);
        step();
        chk("ori_back_fetch", 32'(state), 32'd0);
        op = 6'h08;
        step();
        step();
        chk("addi_exec_ctl", 32'({state, ALUOp, ExtOp}), 32'b1010_000_0);
        step();
        step();
        op = 6'h2B;
        step();
        step();
        chk("sw_memaddr_state", 32'(state), 32'd2);
        step();
        chk("sw_memwrite_ctl", 32'({state, MemWrite, IorD, MemRead}), 32'b0101_1_1_0);
        step();
        chk("sw_back_fetch", 32'(state), 32'd0);
        op = 6'h02;
        step();
        step();
        chk("j_ctl", 32'({state, PCWrite, PCSource}), 32'b1001_1_10);
        step();
        chk("j_back_fetch", 32'(state), 32'd0);

        // 5: illegal and bne
        op = 6'h3F;
        step();
        chk("illegal_pulse", 32'({state, illegal_op}), 32'b0001_1);
        step();
        chk("illegal_back_fetch", 32'({state, illegal_op}), 32'b0000_0);
        op = 6'h05;
        step();
`ifdef MC_BNE_EN
        chk("bne_decode_legal", 32'(illegal_op), 32'd0);
        step();
        chk("bne_branch_ne", 32'({state, BranchNE, PCWriteCond}), 32'b1000_1_1);
        step();
`else
        chk("bne_illegal_pulse", 32'({state, illegal_op}), 32'b0001_1);
        step();
        chk("bne_back_fetch", 32'({state, BranchNE}), 32'b0000_0);
`endif

        // 6: reset while stalled in MEM_READ
        op = 6'h23;
        step();
        step();
        mem_ready = 1'b0;
        step();
        chk("rst_in_memread_state", 32'(state), 32'd3);
        step();
        chk("rst_memread_hold", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        chk("rst_async_zero", 32'(all_outs), 32'h0);
        mem_ready = 1'b1;
        step();
        chk("rst_held_zero", 32'(all_outs), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_release_fetch", 32'({state, MemRead, RegWrite}), 32'b0000_1_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
